// File: rtl/read_length_encoder_pkg.sv
// Shared bridge constants: peripheral width encodings, AHB sizes and the read FSM state type.
// Kept in step with the write-side length decoder so both paths agree on encodings.
package read_length_encoder_pkg;

   localparam logic [3:0] LEN_8  = 4'b0001;
   localparam logic [3:0] LEN_16 = 4'b0010;
   localparam logic [3:0] LEN_32 = 4'b0100;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BEAT = 2'd1,
      DONE = 2'd2
   } state_t;

   // Any size of word or larger is treated as a 4-byte AHB transfer.
   function automatic logic [2:0] ahb_bytes(input logic [2:0] hsize);
      case (hsize)
         HSIZE_BYTE: ahb_bytes = 3'd1;
         HSIZE_HALF: ahb_bytes = 3'd2;
         default:    ahb_bytes = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/read_length_encoder_beat_count_calc.sv
// Combinational beat planner: (HSIZE, SIGNAL_LENGTH) -> APB beat count and peripheral byte width.
// Unknown width encodings fall back to an 8-bit peripheral.
module beat_count_calc
   import read_length_encoder_pkg::*;
(
   input  logic [2:0] i_hsize,
   input  logic [3:0] i_sig_len,
   output logic [2:0] o_beats,
   output logic [2:0] o_pb
);

   logic [2:0] w_ab;

   assign w_ab = ahb_bytes(i_hsize);

   always_comb begin
      o_pb    = 3'd1;
      o_beats = 3'd1;
      case (i_sig_len)
         LEN_16:  o_pb = 3'd2;
         LEN_32:  o_pb = 3'd4;
         default: o_pb = 3'd1;
      endcase
      // A peripheral at least as wide as the AHB transfer always needs one beat.
      case (o_pb)
         3'd1:    o_beats = w_ab;
         3'd2:    o_beats = (w_ab == 3'd4) ? 3'd2 : 3'd1;
         default: o_beats = 3'd1;
      endcase
   end

endmodule

// File: rtl/read_length_encoder.sv
// Gathers 1/2/4 narrow APB read beats into one zero-extended little-endian 32-bit HRDATA word.
// Macro READ_ERR_ABORT_EN: when defined, a PSLVERR beat ends the read early with the bytes gathered so far.
module read_length_encoder
   import read_length_encoder_pkg::*;
(
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HReadReg,
   input  logic [2:0]  HSIZE,
   input  logic [3:0]  SIGNAL_LENGTH,
   input  logic        APB_DONE,
   input  logic [31:0] PRDATA,
   input  logic        PSLVERR,
   input  logic        HREADY,
   output logic        BEAT_REQ,
   output logic [1:0]  BEAT_IDX,
   output logic [31:0] HRDATA,
   output logic        HRDATA_VALID,
   output logic        HRESP_ERR
);

   state_t      r_state;
   state_t      w_next;
   logic [2:0]  r_beats;
   logic [2:0]  r_pb;
   logic [2:0]  r_keep;
   logic [1:0]  r_idx;
   logic [31:0] r_acc;
   logic        r_err;

   logic [2:0]  w_beats;
   logic [2:0]  w_pb;
   logic [2:0]  w_ab;
   logic        w_last;
   logic        w_abort;
   logic        w_beat_fire;
   logic [4:0]  w_shift;
   logic [31:0] w_mask;
   logic [31:0] w_lane;

   beat_count_calc u_calc (
      .i_hsize   (HSIZE),
      .i_sig_len (SIGNAL_LENGTH),
      .o_beats   (w_beats),
      .o_pb      (w_pb)
   );

   assign w_ab   = ahb_bytes(HSIZE);
   assign w_last = ({1'b0, r_idx} == (r_beats - 3'd1));

`ifdef READ_ERR_ABORT_EN
   assign w_abort = PSLVERR;
`else
   assign w_abort = 1'b0;
`endif

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      BEAT_REQ     = 1'b0;
      HRDATA_VALID = 1'b0;
      HRESP_ERR    = 1'b0;
      w_beat_fire  = 1'b0;
      case (r_state)
         IDLE: if (HReadReg) w_next = BEAT;
         BEAT: begin
            BEAT_REQ = 1'b1;
            if (APB_DONE) begin
               w_beat_fire = 1'b1;
               if (w_last || w_abort) w_next = DONE;
            end
         end
         DONE: begin
            HRDATA_VALID = 1'b1;
            HRESP_ERR    = r_err;
            if (HREADY) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Byte lane of the current beat; r_keep trims a peripheral wider than the AHB transfer.
   always_comb begin
      w_shift = 5'd0;
      w_mask  = 32'hFFFF_FFFF;
      case (r_pb)
         3'd1:    w_shift = {r_idx, 3'b000};
         3'd2:    w_shift = {r_idx[0], 4'b0000};
         default: w_shift = 5'd0;
      endcase
      case (r_keep)
         3'd1:    w_mask = 32'h0000_00FF;
         3'd2:    w_mask = 32'h0000_FFFF;
         default: w_mask = 32'hFFFF_FFFF;
      endcase
   end

   assign w_lane = (PRDATA & w_mask) << w_shift;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_beats <= 3'd1;
         r_pb    <= 3'd1;
         r_keep  <= 3'd1;
         r_idx   <= 2'd0;
         r_acc   <= 32'd0;
         r_err   <= 1'b0;
      end else if (r_state == IDLE && HReadReg) begin
         r_beats <= w_beats;
         r_pb    <= w_pb;
         r_keep  <= (w_pb < w_ab) ? w_pb : w_ab;
         r_idx   <= 2'd0;
         r_acc   <= 32'd0;
         r_err   <= 1'b0;
      end else if (w_beat_fire) begin
         r_acc   <= r_acc | w_lane;
         r_idx   <= r_idx + 2'd1;
         r_err   <= r_err | PSLVERR;
      end
   end

   assign HRDATA   = r_acc;
   assign BEAT_IDX = r_idx;

endmodule

// File: tb/tb_read_length_encoder.sv
// Randomized scoreboard bench for read_length_encoder against a byte-level reference model.
module tb_read_length_encoder;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        HReadReg;
   logic [2:0]  HSIZE;
   logic [3:0]  SIGNAL_LENGTH;
   logic        APB_DONE;
   logic [31:0] PRDATA;
   logic        PSLVERR;
   logic        HREADY;
   logic        BEAT_REQ;
   logic [1:0]  BEAT_IDX;
   logic [31:0] HRDATA;
   logic        HRDATA_VALID;
   logic        HRESP_ERR;

   read_length_encoder dut (
      .HCLK          (HCLK),
      .HRESETn       (HRESETn),
      .HReadReg      (HReadReg),
      .HSIZE         (HSIZE),
      .SIGNAL_LENGTH (SIGNAL_LENGTH),
      .APB_DONE      (APB_DONE),
      .PRDATA        (PRDATA),
      .PSLVERR       (PSLVERR),
      .HREADY        (HREADY),
      .BEAT_REQ      (BEAT_REQ),
      .BEAT_IDX      (BEAT_IDX),
      .HRDATA        (HRDATA),
      .HRDATA_VALID  (HRDATA_VALID),
      .HRESP_ERR     (HRESP_ERR)
   );

   always #5 HCLK = ~HCLK;

   int tests = 0;
   int fails = 0;
   int pop_cnt = 0;

   logic [31:0] exp_d_q[$];
   bit          exp_e_q[$];

   logic [31:0] beat_dat[4];
   bit          beat_err[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: concatenate each beat's low peripheral bytes, keep the first AB bytes.
   function automatic void model(input logic [2:0] hs, input logic [3:0] sl,
                                 output int n, output logic [31:0] d, output bit e);
      int pb;
      int ab;
      logic [7:0] q[$];
      pb = (sl == 4'b0010) ? 2 : (sl == 4'b0100) ? 4 : 1;
      ab = (hs == 3'd0) ? 1 : (hs == 3'd1) ? 2 : 4;
      n  = (ab / pb < 1) ? 1 : ab / pb;
      e  = 1'b0;
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < pb; k++) q.push_back(beat_dat[i][8*k +: 8]);
         if (beat_err[i]) begin
            e = 1'b1;
`ifdef READ_ERR_ABORT_EN
            n = i + 1;
            break;
`endif
         end
      end
      d = 32'd0;
      for (int j = 0; j < ab && j < q.size(); j++) d = d | (32'(q[j]) << (8*j));
   endfunction

   always @(negedge HCLK) begin
      if (HRESETn && HRDATA_VALID && HREADY) begin
         if (exp_d_q.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
         end else begin
            chk("hrdata", HRDATA, exp_d_q.pop_front());
            chk("hresp_err", {31'd0, HRESP_ERR}, {31'd0, exp_e_q.pop_front()});
         end
         pop_cnt++;
      end
      if (HRESETn && !HRDATA_VALID) chk("err_outside_done", {31'd0, HRESP_ERR}, 32'd0);
   end

   task automatic do_read(input logic [2:0] hs, input logic [3:0] sl, input int hold);
      int n;
      int pops0;
      logic [31:0] exp_d;
      bit exp_e;
      model(hs, sl, n, exp_d, exp_e);
      exp_d_q.push_back(exp_d);
      exp_e_q.push_back(exp_e);
      HReadReg = 1'b1; HSIZE = hs; SIGNAL_LENGTH = sl;
      @(posedge HCLK); #1;
      HReadReg = 1'b0; HSIZE = 3'($urandom); SIGNAL_LENGTH = 4'($urandom);
      chk("beat_req_start", {31'd0, BEAT_REQ}, 32'd1);
      for (int b = 0; b < n; b++) begin
         repeat ($urandom_range(0, 2)) begin
            PRDATA = $urandom; PSLVERR = 1'($urandom);
            @(posedge HCLK); #1;
         end
         chk("beat_req", {31'd0, BEAT_REQ}, 32'd1);
         chk("beat_idx", {30'd0, BEAT_IDX}, b);
         APB_DONE = 1'b1; PRDATA = beat_dat[b]; PSLVERR = beat_err[b];
         @(posedge HCLK); #1;
         APB_DONE = 1'b0; PSLVERR = 1'b0;
      end
      chk("valid_latency", {31'd0, HRDATA_VALID}, 32'd1);
      chk("beat_req_done", {31'd0, BEAT_REQ}, 32'd0);
      pops0 = pop_cnt;
      repeat (hold) begin
         HReadReg = 1'($urandom); APB_DONE = 1'($urandom);
         PRDATA = $urandom; PSLVERR = 1'($urandom);
         @(posedge HCLK); #1;
         HReadReg = 1'b0; APB_DONE = 1'b0; PSLVERR = 1'b0;
         chk("hold_valid", {31'd0, HRDATA_VALID}, 32'd1);
         chk("hold_data", HRDATA, exp_d);
      end
      HREADY = 1'b1;
      @(posedge HCLK); #1;
      HREADY = 1'b0;
      chk("popped", pop_cnt, pops0 + 1);
      chk("valid_drop", {31'd0, HRDATA_VALID}, 32'd0);
      chk("no_queued_req", {31'd0, BEAT_REQ}, 32'd0);
   endtask

   task automatic set_beats(input logic [31:0] d0, d1, d2, d3, input bit e0, e1);
      beat_dat[0] = d0; beat_dat[1] = d1; beat_dat[2] = d2; beat_dat[3] = d3;
      beat_err[0] = e0; beat_err[1] = e1; beat_err[2] = 1'b0; beat_err[3] = 1'b0;
   endtask

   initial begin
      HRESETn = 1'b0; HReadReg = 1'b0; HSIZE = 3'd0; SIGNAL_LENGTH = 4'd0;
      APB_DONE = 1'b0; PRDATA = 32'd0; PSLVERR = 1'b0; HREADY = 1'b0;
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      chk("rst_beat_req", {31'd0, BEAT_REQ}, 32'd0);
      chk("rst_beat_idx", {30'd0, BEAT_IDX}, 32'd0);
      chk("rst_hrdata", HRDATA, 32'd0);
      chk("rst_valid", {31'd0, HRDATA_VALID}, 32'd0);
      chk("rst_err", {31'd0, HRESP_ERR}, 32'd0);
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
      @(posedge HCLK); #1;

      set_beats(32'hAAAA_AA11, 32'hBBBB_BB22, 32'hCCCC_CC33, 32'hDDDD_DD44, 1'b0, 1'b0);
      do_read(3'd2, 4'b0001, 0);
      set_beats(32'hFFFF_BEEF, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 1'b0);
      do_read(3'd1, 4'b0010, 0);
      set_beats(32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      do_read(3'd0, 4'b0100, 0);
      set_beats(32'h5555_A5C3, 32'h6666_1234, 32'h0, 32'h0, 1'b1, 1'b0);
      do_read(3'd2, 4'b0010, 0);
      set_beats(32'h0102_0304, 32'h0506_0708, 32'h0, 32'h0, 1'b0, 1'b0);
      do_read(3'd2, 4'b0010, 5);

      // Reset in the middle of a 4-beat read discards the partial word.
      set_beats(32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0000_0044, 1'b0, 1'b0);
      HReadReg = 1'b1; HSIZE = 3'd2; SIGNAL_LENGTH = 4'b0001;
      @(posedge HCLK); #1;
      HReadReg = 1'b0;
      APB_DONE = 1'b1; PRDATA = beat_dat[0]; PSLVERR = 1'b1;
      @(posedge HCLK); #1;
      APB_DONE = 1'b0; PSLVERR = 1'b0;
      #2 HRESETn = 1'b0;
      #1;
      chk("arst_beat_req", {31'd0, BEAT_REQ}, 32'd0);
      chk("arst_beat_idx", {30'd0, BEAT_IDX}, 32'd0);
      chk("arst_hrdata", HRDATA, 32'd0);
      chk("arst_valid", {31'd0, HRDATA_VALID}, 32'd0);
      chk("arst_err", {31'd0, HRESP_ERR}, 32'd0);
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
      @(posedge HCLK); #1;
      do_read(3'd2, 4'b0001, 1);

      for (int t = 0; t < 200; t++) begin
         logic [3:0] sl;
         case ($urandom_range(0, 3))
            0:       sl = 4'b0001;
            1:       sl = 4'b0010;
            2:       sl = 4'b0100;
            default: sl = 4'($urandom);
         endcase
         for (int b = 0; b < 4; b++) begin
            beat_dat[b] = $urandom;
            beat_err[b] = ($urandom_range(0, 5) == 0);
         end
         do_read(3'($urandom), sl, $urandom_range(0, 3));
         repeat ($urandom_range(0, 2)) @(posedge HCLK);
         #1;
      end

      chk("queue_drained", exp_d_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
